// File: rtl/tile_lane.sv
// tile_lane -- one falling-tile lane of a rhythm game.
//
// One tile falls down a vertical lane. The lane issues one pixel write per
// cycle to a shared frame-buffer arbiter. The tile is drawn once in full.
// It then moves down one row per step: the lane erases the top row, draws a
// new bottom row, and waits STEP_DIV cycles. A key press scores a hit when
// the tile is low enough, and a miss otherwise. A tile that reaches the
// screen bottom with no press also scores a miss. In every one of these
// cases the tile is cleared and a new tile is drawn at the top.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   grant          arbiter accepts the presented pixel this cycle
//   key            lane key, active-high level
//   req            pixel write request, decoded from state
//   X, Y, color    pixel being presented; they hold while the write stalls
//   state          FSM state encoding (see state_t)
//   start_y/end_y  current tile top and bottom rows
//   hit/miss       one-cycle score pulses, registered
//   hits/misses    score counters that saturate at 255
module tile_lane #(
  parameter logic [9:0]  X_START  = 10'd0,
  parameter logic [9:0]  X_END    = 10'd159,
  parameter logic [8:0]  TILE_H   = 9'd120,
  parameter logic [8:0]  SCREEN_H = 9'd480,
  parameter logic [25:0] STEP_DIV = 26'd5,
  parameter logic [8:0]  HIT_ZONE = 9'd360
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant,
  input  logic       key,
  output logic       req,
  output logic [9:0] X,
  output logic [8:0] Y,
  output logic [2:0] color,
  output logic [2:0] state,
  output logic [8:0] start_y,
  output logic [8:0] end_y,
  output logic       hit,
  output logic       miss,
  output logic [7:0] hits,
  output logic [7:0] misses
);

  typedef enum logic [2:0] {
    DRAW_RECT   = 3'd0,
    ERASE_TOP   = 3'd1,
    DRAW_BOTTOM = 3'd2,
    DELAY       = 3'd3,
    CLEAR_TILE  = 3'd4
  } state_t;

  state_t      st;
  logic [25:0] counter;
  logic        key_prev;
  logic [8:0]  clear_end;

  logic commit;
  logic x_last;
  logic key_edge;

  // req and color are decoded from the state register alone, so they are
  // glitch-free with respect to grant and key.
  always_comb begin
    req   = (st != DELAY);
    color = ((st == ERASE_TOP) || (st == CLEAR_TILE)) ? 3'b000 : 3'b111;
  end

  assign state    = st;
  assign commit   = req && grant;
  assign x_last   = (X == X_END);
  assign key_edge = key && !key_prev;

  // NOTE: every register in this block uses non-blocking assignment. Each
  // branch then reads the values from before the edge, and the branch order
  // does not create hidden ordering between registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= DRAW_RECT;
      X         <= X_START;
      Y         <= 9'd0;
      start_y   <= 9'd0;
      end_y     <= TILE_H - 9'd1;
      hit       <= 1'b0;
      miss      <= 1'b0;
      hits      <= 8'd0;
      misses    <= 8'd0;
      counter   <= 26'd0;
      key_prev  <= 1'b0;
      clear_end <= 9'd0;
    end else begin
      key_prev <= key;
      hit      <= 1'b0;
      miss     <= 1'b0;

      // A press overrides all normal progress, including a DELAY exit on
      // the same cycle. Only one score pulse results.
      if (key_edge && (st != CLEAR_TILE)) begin
        if (end_y >= HIT_ZONE) begin
          hit <= 1'b1;
          if (hits != 8'hFF) hits <= hits + 8'd1;
        end else begin
          miss <= 1'b1;
          if (misses != 8'hFF) misses <= misses + 8'd1;
        end
        // A press in DRAW_BOTTOM can leave row end_y+1 partly painted.
        // The clear therefore has to cover that row too.
        clear_end <= (st == DRAW_BOTTOM) ? end_y + 9'd1 : end_y;
        st        <= CLEAR_TILE;
        X         <= X_START;
        Y         <= start_y;
      end else begin
        unique case (st)
          DRAW_RECT: begin
            if (commit) begin
              if (x_last) begin
                X <= X_START;
                if (Y == end_y) begin
                  st <= ERASE_TOP;
                  Y  <= start_y;
                end else begin
                  Y <= Y + 9'd1;
                end
              end else begin
                X <= X + 10'd1;
              end
            end
          end

          ERASE_TOP: begin
            if (commit) begin
              if (x_last) begin
                st <= DRAW_BOTTOM;
                X  <= X_START;
                Y  <= end_y + 9'd1;
              end else begin
                X <= X + 10'd1;
              end
            end
          end

          DRAW_BOTTOM: begin
            if (commit) begin
              if (x_last) begin
                st      <= DELAY;
                X       <= X_START;
                start_y <= start_y + 9'd1;
                end_y   <= end_y + 9'd1;
                counter <= 26'd0;
              end else begin
                X <= X + 10'd1;
              end
            end
          end

          DELAY: begin
            if (counter == STEP_DIV - 26'd1) begin
              X <= X_START;
              Y <= start_y;
              if (end_y == SCREEN_H - 9'd1) begin
                // The tile has reached the screen bottom with no press.
                miss      <= 1'b1;
                if (misses != 8'hFF) misses <= misses + 8'd1;
                clear_end <= end_y;
                st        <= CLEAR_TILE;
              end else begin
                st <= ERASE_TOP;
              end
            end else begin
              counter <= counter + 26'd1;
            end
          end

          CLEAR_TILE: begin
            if (commit) begin
              if (x_last) begin
                X <= X_START;
                if (Y == clear_end) begin
                  st      <= DRAW_RECT;
                  Y       <= 9'd0;
                  start_y <= 9'd0;
                  end_y   <= TILE_H - 9'd1;
                end else begin
                  Y <= Y + 9'd1;
                end
              end else begin
                X <= X + 10'd1;
              end
            end
          end

          default: st <= DRAW_RECT;
        endcase
      end
    end
  end

endmodule

// File: doc/tile_lane.md
TILE_LANE -- requirements
Module: tile_lane

Interface
REQ-001 Parameter X_START, default 10'd0, leftmost lane pixel column (inclusive).
REQ-002 Parameter X_END, default 10'd159, rightmost lane pixel column (inclusive); X_END >= X_START.
REQ-003 Parameter TILE_H, default 9'd120, tile height in rows.
REQ-004 Parameter SCREEN_H, default 9'd480, screen height in rows; TILE_H < SCREEN_H.
REQ-005 Parameter STEP_DIV, default 26'd5, DELAY cycles between one-row tile steps.
REQ-006 Parameter HIT_ZONE, default 9'd360, minimum end_y at which a key press counts as a hit.
REQ-007 clk  in  1  system clock; one clock, all state on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 grant  in  1  arbiter accepts the current pixel this cycle.
REQ-010 key  in  1  lane key, active-high level.
REQ-011 req  out  1  pixel write request, combinational from state.
REQ-012 X  out  10  pixel column of the current request.
REQ-013 Y  out  9  pixel row of the current request.
REQ-014 color  out  3  pixel color of the current request.
REQ-015 state  out  3  FSM state: DRAW_RECT=0, ERASE_TOP=1, DRAW_BOTTOM=2, DELAY=3, CLEAR_TILE=4.
REQ-016 start_y / end_y  out  9 each  current tile top and bottom rows.
REQ-017 hit / miss  out  1 each  registered one-cycle event pulses.
REQ-018 hits / misses  out  8 each  event counters, saturating at 255.

Function
REQ-019 req SHALL be 1 in DRAW_RECT, ERASE_TOP, DRAW_BOTTOM and CLEAR_TILE, and 0 in DELAY.
REQ-020 color SHALL be 3'b000 in ERASE_TOP and CLEAR_TILE, and 3'b111 otherwise.
REQ-021 A pixel SHALL be committed only on a cycle with req && grant; X, Y and color SHALL hold while req && !grant.
REQ-022 Each committed pixel SHALL advance X by 1; at X_END, X SHALL wrap to X_START and Y SHALL advance per the state.
REQ-023 DRAW_RECT SHALL paint rows start_y..end_y; after the pixel (X_END, end_y) commits, state SHALL go to ERASE_TOP with X=X_START, Y=start_y.
REQ-024 ERASE_TOP SHALL paint row start_y; after X_END commits, state SHALL go to DRAW_BOTTOM with X=X_START, Y=end_y+1.
REQ-025 DRAW_BOTTOM SHALL paint row end_y+1; after X_END commits, start_y and end_y SHALL each increment, the counter SHALL clear, and state SHALL go to DELAY.
REQ-026 DELAY SHALL last exactly STEP_DIV cycles (counter 0..STEP_DIV-1) and then exit.
REQ-027 On DELAY exit with end_y < SCREEN_H-1, state SHALL go to ERASE_TOP with X=X_START, Y=start_y.
REQ-028 On DELAY exit with end_y == SCREEN_H-1, miss SHALL pulse, clear_end SHALL be set to end_y, and state SHALL go to CLEAR_TILE with X=X_START, Y=start_y.
REQ-029 A key rising edge SHALL be detected as key && !key_prev; key_prev SHALL be registered every cycle; a held key SHALL yield one edge only.
REQ-030 A key edge in any state except CLEAR_TILE SHALL pulse hit if end_y >= HIT_ZONE, else miss, and SHALL then enter CLEAR_TILE with X=X_START, Y=start_y.
REQ-031 On that key edge, clear_end SHALL be end_y+1 if the state was DRAW_BOTTOM, else end_y.
REQ-032 A key edge during CLEAR_TILE SHALL be ignored.
REQ-033 A key edge SHALL take priority over a same-cycle DELAY exit and SHALL produce exactly one pulse.
REQ-034 CLEAR_TILE SHALL paint rows start_y..clear_end.
REQ-035 After the last CLEAR_TILE pixel commits, start_y SHALL be 0, end_y SHALL be TILE_H-1, X SHALL be X_START, Y SHALL be 0, and state SHALL be DRAW_RECT.
REQ-036 hits SHALL increment on each hit pulse and misses on each miss pulse; both SHALL hold at 255.

Reset
REQ-037 On reset: state=DRAW_RECT, X=X_START, Y=0, start_y=0, end_y=TILE_H-1, hit=miss=0, hits=misses=0, counter=0, key_prev=0, clear_end=0.
REQ-038 Reset SHALL take effect from any state, including mid-CLEAR_TILE and mid-stall, on the next rising edge.

Verification (X_START=0, X_END=3, TILE_H=4, SCREEN_H=8, STEP_DIV=2, HIT_ZONE=6)
REQ-039 Reset, then grant=1 -> 16 color-7 writes over (0..3,0..3), 4 color-0 writes on row 0, 4 color-7 writes on row 4, then start_y=1, end_y=4, req=0 for 2 cycles.
REQ-040 grant=0 for 5 cycles mid-DRAW_RECT -> X/Y/color frozen, no advance; grant=1 resumes at the same pixel.
REQ-041 Key edge while in DELAY with end_y=4 -> miss=1 for one cycle, misses=1, rows 1..4 cleared, then redraw at rows 0..3.
REQ-042 Key edge while in DRAW_BOTTOM with end_y=6 -> hit=1, hits=1, rows 3..7 cleared; key held high for 10 cycles -> no further pulse.
REQ-043 No key press -> tile reaches end_y=7, after DELAY miss=1, rows 4..7 cleared, redraw at rows 0..3.
REQ-044 Reset asserted mid-CLEAR_TILE -> all REQ-037 values on the next cycle, req=1.
